// File: rtl/xcvr_pkg.sv
// Shared types and constants for the transceiver transfer controller.
// Holds the FSM state encoding and the registered control-pin bundle.
package xcvr_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_LATCH,
        WR_DRIVE,
        RD_WAIT,
        RD_LATCH,
        RD_HOLD,
        FINISH,
        ABORT,
        RETRY
    } xfer_state_t;

    localparam logic DIR_A2B      = 1'b1;
    localparam logic DIR_B2A      = 1'b0;
    localparam logic SEL_REALTIME = 1'b0;
    localparam logic SEL_STORED   = 1'b1;

    typedef struct packed {
        logic clkab;
        logic clkba;
        logic dir;
        logic oe_n;
        logic sab;
        logic sba;
        logic busy;
        logic done;
        logic err;
    } xcvr_ctrl_t;

    // Safe bus state: outputs disabled, A-to-B direction, real-time paths.
    function automatic xcvr_ctrl_t idle_ctrl();
        xcvr_ctrl_t c;
        c.clkab = 1'b0;
        c.clkba = 1'b0;
        c.dir   = DIR_A2B;
        c.oe_n  = 1'b1;
        c.sab   = SEL_REALTIME;
        c.sba   = SEL_REALTIME;
        c.busy  = 1'b0;
        c.done  = 1'b0;
        c.err   = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/xcvr_cycle_timer.sv
// Saturating cycle counter with synchronous clear/enable and an
// equality compare against a caller-supplied match value.
module xcvr_cycle_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] match,
    output logic             hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hit = (count == match);

endmodule

// File: rtl/xcvr_xfer_ctrl.sv
// Control sequencer for a pair of registered bus transceivers (CPU A-side <-> bus B-side).
// Optional single retry on timeout when XCVR_XFER_CTRL_RETRY_EN is defined.
module xcvr_xfer_ctrl
    import xcvr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 63,
    parameter int HOLD_CYCLES    = 2,
    parameter int CNT_W          = 6
) (
    input  logic sysclk,
    input  logic sys_rst,
    input  logic req_wr,
    input  logic req_rd,
    input  logic bus_ack,
    output logic xcvr_clkab,
    output logic xcvr_clkba,
    output logic xcvr_dir,
    output logic xcvr_oe_n,
    output logic xcvr_sab,
    output logic xcvr_sba,
    output logic busy,
    output logic done,
    output logic err
);

    // The counter starts at 0 in the first cycle of a state, so matching
    // N-1 makes the state last exactly N cycles.
    localparam logic [CNT_W-1:0] TO_MATCH   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MATCH = CNT_W'(HOLD_CYCLES - 1);

    xfer_state_t      state;
    xfer_state_t      state_next;
    xfer_state_t      timeout_state;
    xcvr_ctrl_t       ctrl_q;
    xcvr_ctrl_t       ctrl_next;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_hit;
    logic [CNT_W-1:0] cnt_match;

`ifdef XCVR_XFER_CTRL_RETRY_EN
    logic retry_q;
    logic retry_next;
`endif

    xcvr_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (sysclk),
        .rst   (sys_rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .match (cnt_match),
        .hit   (cnt_hit)
    );

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= IDLE;
            ctrl_q <= idle_ctrl();
        end else begin
            state  <= state_next;
            ctrl_q <= ctrl_next;
        end
    end

`ifdef XCVR_XFER_CTRL_RETRY_EN
    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            retry_q <= 1'b0;
        end else begin
            retry_q <= retry_next;
        end
    end
`endif

    always_comb begin
        state_next = state;
        cnt_en     = 1'b0;
        cnt_match  = (state == RD_HOLD) ? HOLD_MATCH : TO_MATCH;

`ifdef XCVR_XFER_CTRL_RETRY_EN
        timeout_state = retry_q ? ABORT : RETRY;
`else
        timeout_state = ABORT;
`endif

        case (state)
            IDLE: begin
                if (req_wr) begin
                    state_next = WR_LATCH;
                end else if (req_rd) begin
                    state_next = RD_WAIT;
                end
            end
            WR_LATCH: state_next = WR_DRIVE;
            WR_DRIVE: begin
                cnt_en = 1'b1;
                if (bus_ack) begin
                    state_next = FINISH;
                end else if (cnt_hit) begin
                    state_next = timeout_state;
                end
            end
            RD_WAIT: begin
                cnt_en = 1'b1;
                if (bus_ack) begin
                    state_next = RD_LATCH;
                end else if (cnt_hit) begin
                    state_next = timeout_state;
                end
            end
            RD_LATCH: state_next = RD_HOLD;
            RD_HOLD: begin
                cnt_en = 1'b1;
                if (cnt_hit) begin
                    state_next = FINISH;
                end
            end
            FINISH: state_next = IDLE;
            ABORT:  state_next = IDLE;
`ifdef XCVR_XFER_CTRL_RETRY_EN
            // RETRY keeps the direction of the interrupted transfer.
            RETRY:  state_next = (ctrl_q.dir == DIR_A2B) ? WR_LATCH : RD_WAIT;
`endif
            default: state_next = IDLE;
        endcase

        // Every state entry starts from a zero count.
        cnt_clr = (state_next != state);

`ifdef XCVR_XFER_CTRL_RETRY_EN
        retry_next = (state == IDLE) ? 1'b0 : (retry_q || (state_next == RETRY));
`endif

        ctrl_next      = idle_ctrl();
        ctrl_next.busy = (state_next != IDLE);
        case (state_next)
            WR_LATCH: ctrl_next.clkab = 1'b1;
            WR_DRIVE: begin
                ctrl_next.oe_n = 1'b0;
                ctrl_next.sab  = SEL_STORED;
            end
            RD_WAIT:  ctrl_next.dir = DIR_B2A;
            RD_LATCH: begin
                ctrl_next.clkba = 1'b1;
                ctrl_next.dir   = DIR_B2A;
            end
            RD_HOLD: begin
                ctrl_next.dir  = DIR_B2A;
                ctrl_next.sba  = SEL_STORED;
                ctrl_next.oe_n = 1'b0;
            end
            FINISH:   ctrl_next.done = 1'b1;
            ABORT:    ctrl_next.err  = 1'b1;
            RETRY:    ctrl_next.dir  = ctrl_q.dir;
            default:  ;
        endcase
    end

    assign xcvr_clkab = ctrl_q.clkab;
    assign xcvr_clkba = ctrl_q.clkba;
    assign xcvr_dir   = ctrl_q.dir;
    assign xcvr_oe_n  = ctrl_q.oe_n;
    assign xcvr_sab   = ctrl_q.sab;
    assign xcvr_sba   = ctrl_q.sba;
    assign busy       = ctrl_q.busy;
    assign done       = ctrl_q.done;
    assign err        = ctrl_q.err;

endmodule
